// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes and
// the LSU control state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath for the LSU: store strobes and lane replication,
// load lane extraction with sign/zero extension, and access legality.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            wstrb,
    output logic [DATA_WIDTH-1:0] wdata_rep,
    output logic [DATA_WIDTH-1:0] rdata_ext,
    output logic                  err
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        err       = 1'b0;
        wstrb     = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = '0;

        // Stores share the low funct3 codes with loads; funct3[2] is load-only.
        case (funct3)
            F3_LB:   err = 1'b0;
            F3_LH:   err = addr_lo[0];
            F3_LW:   err = |addr_lo;
            F3_LBU:  err = we;
            F3_LHU:  err = we | addr_lo[0];
            default: err = 1'b1;
        endcase

        if (we) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrb     = 4'b0001 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                2'b01: begin
                    wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_rep = {2{wdata[15:0]}};
                end
                default: begin
                    wstrb     = 4'b1111;
                    wdata_rep = wdata;
                end
            endcase
        end

        case (funct3)
            F3_LB:   rdata_ext = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            F3_LH:   rdata_ext = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            F3_LW:   rdata_ext = rdata;
            F3_LBU:  rdata_ext = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            F3_LHU:  rdata_ext = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one core access at a time, issues a single
// word-aligned memory request and returns an extended result or an error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  idle;
    logic                  al_we;
    logic [2:0]            al_funct3;
    logic [1:0]            al_addr_lo;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [3:0]            al_wstrb;
    logic [DATA_WIDTH-1:0] al_wdata_rep;
    logic [DATA_WIDTH-1:0] al_rdata_ext;
    logic                  al_err;

    // In IDLE the aligner judges the incoming request; afterwards the latched one.
    assign idle       = (state_q == ST_IDLE);
    assign al_we      = idle ? req_we          : we_q;
    assign al_funct3  = idle ? req_funct3      : funct3_q;
    assign al_addr_lo = idle ? req_addr[1:0]   : addr_q[1:0];
    assign al_wdata   = idle ? req_wdata       : wdata_q;

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .we        (al_we),
        .funct3    (al_funct3),
        .addr_lo   (al_addr_lo),
        .wdata     (al_wdata),
        .rdata     (mem_rdata),
        .wstrb     (al_wstrb),
        .wdata_rep (al_wdata_rep),
        .rdata_ext (al_rdata_ext),
        .err       (al_err)
    );

    assign mem_req    = (state_q == ST_REQ);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_wstrb  = mem_req ? al_wstrb : 4'b0000;
    assign mem_wdata  = mem_req ? al_wdata_rep : '0;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;
    assign req_ready  = idle;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = al_err;
                    if (al_err) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = al_rdata_ext;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte-address width on core and memory sides, SHALL be supported.
REQ-002 Parameter DATA_WIDTH, 32, data word width, SHALL be supported; only 32 is required to work.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  core presents a load/store.
REQ-006 req_ready  out  1  LSU accepts the request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 req_addr  in  ADDR_WIDTH  byte address.
REQ-010 req_wdata  in  DATA_WIDTH  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  DATA_WIDTH  extended load result.
REQ-013 resp_err  out  1  misaligned or illegal access, valid with resp_valid.
REQ-014 mem_req  out  1  request to data memory.
REQ-015 mem_gnt  in  1  memory accepts the request.
REQ-016 mem_we  out  1  write enable to memory.
REQ-017 mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
REQ-018 mem_wstrb  out  4  byte-lane write strobes.
REQ-019 mem_wdata  out  DATA_WIDTH  lane-replicated store data.
REQ-020 mem_rvalid  in  1  read data valid.
REQ-021 mem_rdata  in  DATA_WIDTH  full memory word.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-023 On req_valid & req_ready the LSU SHALL latch we, funct3, addr, wdata and move to REQ, or to RESP with error per REQ-024.
REQ-024 Error: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, funct3 011/110/111, or store with funct3[2]=1 -> no mem_req, resp_err=1, resp_rdata=0.
REQ-025 In REQ, mem_req=1 with mem_addr/mem_we/mem_wstrb/mem_wdata held stable until the cycle mem_gnt=1.
REQ-026 On grant: store -> RESP; load -> WAIT; mem_gnt outside REQ SHALL be ignored.
REQ-027 In WAIT, mem_rvalid=1 SHALL capture extracted data and move to RESP; mem_rvalid in any other state SHALL be ignored; mem_rvalid coincident with grant is not legal.
REQ-028 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-029 Strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<(2*addr[1]); SW 4'b1111; loads 4'b0000.
REQ-030 mem_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-031 Loads: byte lane addr[1:0], halfword lane addr[1]; sign-extend when funct3[2]=0, zero-extend when 1.
REQ-032 resp_rdata SHALL be 0 for stores and errors and SHALL hold until the next RESP.
REQ-033 Best-case latency: load accepted cycle 0, gnt cycle 1, rvalid cycle 2 -> resp_valid cycle 3; store with gnt cycle 1 -> resp_valid cycle 2; error -> resp_valid cycle 1.

Reset
REQ-034 While rst_n=0: state IDLE, mem_req/mem_we/resp_valid/resp_err=0, mem_wstrb=0, mem_addr/mem_wdata/resp_rdata=0, req_ready=1.
REQ-035 Reset mid-transaction SHALL abandon it immediately: mem_req drops asynchronously, no resp_valid issued.

Structure
REQ-036 Shared package SHALL hold funct3 constants (LB..LHU, SB..SW) and the LSU state encoding.
REQ-037 Combinational sub-module lsu_align SHALL compute strobes, lane replication, load extraction/extension and error flag.

Verification
REQ-038 SB addr 0x0000_0013 data 0xAB, gnt immediate -> mem_addr 0x10, wstrb 4'b1000, wdata 0xABABABAB, resp_valid 2 cycles after accept.
REQ-039 LB addr 0x12, mem_rdata 0x0080_0000 -> resp_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-040 LH addr 0x22, mem_rdata 0x8001_1234 -> 0xFFFF_8001; LHU -> 0x0000_8001.
REQ-041 LW addr 0x05 -> no mem_req, resp_valid with resp_err=1, resp_rdata=0, 1 cycle after accept.
REQ-042 mem_gnt withheld 5 cycles -> mem_req and all mem_* outputs stable; spurious mem_rvalid in IDLE ignored.
REQ-043 rst_n asserted in WAIT -> mem_req=0 and state IDLE immediately, no resp_valid; next LW completes normally.
